// File: rtl/pwm_comparador_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_comparador_if
// Description : Signal bundle between the PWM comparator and its environment.
//               master : drives run request, counter value and duty handshake
//                        (en, count_in, duty_in, duty_valid); observes outputs.
//               slave  : the comparator; drives duty_ready, pwm_out,
//                        period_tick and duty_active.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_comparador_if;
   logic       en;           // run request
   logic [8:0] count_in;     // free-running upstream count, wraps 511->0
   logic [8:0] duty_in;      // new duty value (high cycles per period)
   logic       duty_valid;   // duty_in is valid
   logic       duty_ready;   // comparator can accept a duty value
   logic       pwm_out;      // PWM waveform
   logic       period_tick;  // one-cycle end-of-period pulse
   logic [8:0] duty_active;  // duty value currently in use

   modport master (
      output en, count_in, duty_in, duty_valid,
      input  duty_ready, pwm_out, period_tick, duty_active
   );

   modport slave (
      input  en, count_in, duty_in, duty_valid,
      output duty_ready, pwm_out, period_tick, duty_active
   );
endinterface
`default_nettype wire

// File: rtl/pwm_comparador.sv
`default_nettype none
// ============================================================================
// Module      : pwm_comparador
// Description : Compares an external 9-bit free-running count against a
//               shadowed duty value to generate a glitch-free PWM waveform.
//               New duty values are accepted through a valid/ready handshake
//               into a one-entry pending register and applied only at a
//               period boundary while running (immediately when idle).
// Ports       : clk   - rising-edge clock shared with the upstream counter
//               reset - synchronous, active-high
//               bus   - pwm_comparador_if.slave (en, count_in, duty_in,
//                       duty_valid in; duty_ready, pwm_out, period_tick,
//                       duty_active out, all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_comparador (
   input  wire logic          clk,
   input  wire logic          reset,
   pwm_comparador_if.slave    bus
);

   localparam logic [8:0] C_LAST_COUNT = 9'd511;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t     state_q,      state_d;
   logic       pwm_q,        pwm_d;
   logic       tick_q,       tick_d;
   logic       ready_q,      ready_d;
   logic       pend_q,       pend_d;
   logic [8:0] pend_val_q,   pend_val_d;
   logic [8:0] active_q,     active_d;

   logic w_at_wrap;
   logic w_live;
   logic w_xfer;
   logic w_apply;

   always_comb begin
      w_at_wrap = (bus.count_in == C_LAST_COUNT);
      w_live    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      w_xfer    = bus.duty_valid && ready_q;
      // While running the shadow value only lands on the wrap so a period is
      // never split between two duty values; when stopped it lands at once.
      w_apply   = pend_q && (!w_live || w_at_wrap);

      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.en) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            // Dropping en wins over a coincident wrap: no run is started.
            if (!bus.en)         state_d = ST_IDLE;
            else if (w_at_wrap)  state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!bus.en) state_d = w_at_wrap ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (bus.en)          state_d = ST_RUN;
            else if (w_at_wrap)  state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      pwm_d  = w_live && (bus.count_in < active_q);
      tick_d = w_live && w_at_wrap;

      pend_val_d = w_xfer ? bus.duty_in : pend_val_q;
      // A transfer needs ready, and ready implies the pending slot is empty,
      // so a capture and an apply can never coincide.
      pend_d     = w_xfer || (pend_q && !w_apply);
      active_d   = w_apply ? pend_val_q : active_q;
      // Ready is derived from the previous pending flag, so it returns one
      // cycle after the slot empties.
      ready_d    = !(pend_q || w_xfer);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pwm_q      <= 1'b0;
         tick_q     <= 1'b0;
         ready_q    <= 1'b1;
         pend_q     <= 1'b0;
         pend_val_q <= 9'd0;
         active_q   <= 9'd0;
      end else begin
         state_q    <= state_d;
         pwm_q      <= pwm_d;
         tick_q     <= tick_d;
         ready_q    <= ready_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         active_q   <= active_d;
      end
   end

   assign bus.duty_ready  = ready_q;
   assign bus.pwm_out     = pwm_q;
   assign bus.period_tick = tick_q;
   assign bus.duty_active = active_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_comparador.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_comparador
// Description : Self-checking bench for pwm_comparador. A behavioural model
//               is compared against every output on every cycle; a table of
//               duty values checks per-period high counts, and directed
//               sequences cover shadow update, wrap transfer, drain and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_comparador;

   logic clk;
   logic reset;
   pwm_comparador_if bus_if ();

   pwm_comparador dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int prints = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Modes: stopped, waiting for period alignment, producing, finishing.
   localparam int M_STOP = 0, M_ALIGN = 1, M_GO = 2, M_FINISH = 3;
   int m_mode;
   bit m_pwm, m_tick, m_ready, m_pend, m_ok;
   int m_active, m_pend_val;

   initial m_ok = 1'b0;

   always @(posedge clk) begin
      bit wrap, live, xfer, nready;
      if (reset) begin
         m_mode = M_STOP; m_pwm = 0; m_tick = 0; m_active = 0;
         m_pend = 0; m_ready = 1; m_ok = 1;
      end else if (m_ok) begin
         wrap   = (int'(bus_if.count_in) == 511);
         live   = (m_mode == M_GO) || (m_mode == M_FINISH);
         xfer   = bus_if.duty_valid && m_ready;
         m_pwm  = live && (int'(bus_if.count_in) < m_active);
         m_tick = live && wrap;
         nready = !(m_pend || xfer);
         if (m_pend && (!live || wrap)) begin
            m_active = m_pend_val;
            m_pend   = 0;
         end
         if (xfer) begin
            m_pend     = 1;
            m_pend_val = int'(bus_if.duty_in);
         end
         m_ready = nready;
         if (m_mode == M_STOP) begin
            if (bus_if.en) m_mode = M_ALIGN;
         end else if (m_mode == M_ALIGN) begin
            m_mode = !bus_if.en ? M_STOP : (wrap ? M_GO : M_ALIGN);
         end else if (m_mode == M_GO) begin
            if (!bus_if.en) m_mode = wrap ? M_STOP : M_FINISH;
         end else begin
            m_mode = bus_if.en ? M_GO : (wrap ? M_STOP : M_FINISH);
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         checks++;
         if (bus_if.pwm_out !== m_pwm || bus_if.period_tick !== m_tick ||
             bus_if.duty_ready !== m_ready || bus_if.duty_active !== 9'(m_active)) begin
            errors++;
            if (prints < 20) begin
               prints++;
               $display("FAIL model t=%0t: got pwm=%b tick=%b ready=%b active=%0d, expected pwm=%b tick=%b ready=%b active=%0d",
                        $time, bus_if.pwm_out, bus_if.period_tick, bus_if.duty_ready,
                        bus_if.duty_active, m_pwm, m_tick, m_ready, m_active);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // One clock: wait for the edge, then advance the upstream counter.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus_if.count_in = bus_if.count_in + 9'd1;
      end
   endtask

   task automatic wait_count(input int v);
      int guard = 0;
      while (int'(bus_if.count_in) != v && guard < 600) begin
         cyc(1);
         guard++;
      end
      if (guard >= 600) chk("wait_count_timeout", guard, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
   endtask

   task automatic send_duty(input int d);
      bus_if.duty_in    = 9'(d);
      bus_if.duty_valid = 1'b1;
      cyc(1);
      bus_if.duty_valid = 1'b0;
   endtask

   // Observe n cycles: pwm highs, ticks, and cycles where pwm disagrees with
   // "count one cycle ago < duty".
   task automatic measure(input int n, input int duty,
                          output int highs, output int ticks, output int misal);
      int pc;
      highs = 0; ticks = 0; misal = 0;
      for (int i = 0; i < n; i++) begin
         pc = int'(bus_if.count_in);
         cyc(1);
         highs += int'(bus_if.pwm_out);
         ticks += int'(bus_if.period_tick);
         if (bus_if.pwm_out !== (pc < duty)) misal++;
      end
   endtask

   typedef struct {
      int duty;
      int exp_high;   // over three full periods
      int exp_ticks;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int h, t, m, seen;
      vecs[0] = '{duty: 0,   exp_high: 0,    exp_ticks: 3};
      vecs[1] = '{duty: 1,   exp_high: 3,    exp_ticks: 3};
      vecs[2] = '{duty: 100, exp_high: 300,  exp_ticks: 3};
      vecs[3] = '{duty: 256, exp_high: 768,  exp_ticks: 3};
      vecs[4] = '{duty: 511, exp_high: 1533, exp_ticks: 3};

      reset = 1'b1;
      bus_if.en = 1'b0;
      bus_if.count_in = 9'd37;
      bus_if.duty_in = 9'd0;
      bus_if.duty_valid = 1'b0;
      cyc(2);
      reset = 1'b0;

      chk("reset_pwm",    int'(bus_if.pwm_out), 0);
      chk("reset_tick",   int'(bus_if.period_tick), 0);
      chk("reset_active", int'(bus_if.duty_active), 0);
      chk("reset_ready",  int'(bus_if.duty_ready), 1);

      // -------- table: duty load in idle, then three full periods --------
      foreach (vecs[k]) begin
         do_reset();
         bus_if.en = 1'b0;
         send_duty(vecs[k].duty);
         chk("idle_ready_low", int'(bus_if.duty_ready), 0);
         cyc(1);
         chk("idle_apply", int'(bus_if.duty_active), vecs[k].duty);
         cyc(1);
         chk("idle_ready_back", int'(bus_if.duty_ready), 1);
         bus_if.en = 1'b1;
         cyc(600);
         measure(1536, vecs[k].duty, h, t, m);
         chk("table_highs", h, vecs[k].exp_high);
         chk("table_ticks", t, vecs[k].exp_ticks);
         chk("table_align", m, 0);
      end

      // -------- shadow update: 100 running, 300 sent at count 200 --------
      do_reset();
      send_duty(100);
      bus_if.en = 1'b1;
      cyc(600);
      wait_count(200);
      send_duty(300);
      chk("shadow_ready_low", int'(bus_if.duty_ready), 0);
      wait_count(511);
      chk("shadow_ready_wrap", int'(bus_if.duty_ready), 0);
      chk("shadow_old_duty", int'(bus_if.duty_active), 100);
      cyc(1);
      chk("shadow_new_duty", int'(bus_if.duty_active), 300);
      chk("shadow_ready_wrap1", int'(bus_if.duty_ready), 0);
      cyc(1);
      chk("shadow_ready_wrap2", int'(bus_if.duty_ready), 1);
      measure(512, 300, h, t, m);
      chk("shadow_next_highs", h, 300);

      // -------- transfer exactly at the wrap --------
      wait_count(511);
      send_duty(50);
      chk("wrapxfer_not_applied", int'(bus_if.duty_active), 300);
      wait_count(511);
      chk("wrapxfer_still_old", int'(bus_if.duty_active), 300);
      cyc(1);
      chk("wrapxfer_applied", int'(bus_if.duty_active), 50);

      // -------- drain to idle --------
      wait_count(10);
      bus_if.en = 1'b0;
      cyc(1);
      wait_count(511);
      cyc(1);
      chk("drain_final_tick", int'(bus_if.period_tick), 1);
      measure(600, 0, h, t, m);
      chk("drain_idle_pwm", h, 0);
      chk("drain_idle_ticks", t, 0);

      // -------- drain then resume: no missing period --------
      bus_if.en = 1'b1;
      wait_count(511);
      cyc(1);
      wait_count(10);
      bus_if.en = 1'b0;
      cyc(20);
      bus_if.en = 1'b1;
      cyc(1);
      measure(512, 50, h, t, m);
      chk("resume_highs", h, 50);
      chk("resume_ticks", t, 1);

      // -------- mid-operation reset with a pending value --------
      wait_count(100);
      send_duty(200);
      wait_count(511);
      cyc(2);
      chk("pre_reset_duty", int'(bus_if.duty_active), 200);
      wait_count(30);
      send_duty(400);
      wait_count(60);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("midreset_pwm",    int'(bus_if.pwm_out), 0);
      chk("midreset_active", int'(bus_if.duty_active), 0);
      chk("midreset_ready",  int'(bus_if.duty_ready), 1);
      seen = 0;
      for (int i = 0; i < 1100; i++) begin
         cyc(1);
         if (int'(bus_if.duty_active) == 400) seen++;
      end
      chk("midreset_pending_gone", seen, 0);

      // -------- randomized stimulus against the model --------
      for (int i = 0; i < 20000; i++) begin
         cyc(1);
         reset = ($urandom_range(0, 1999) == 0);
         if ($urandom_range(0, 99) < 2) bus_if.en = ~bus_if.en;
         bus_if.duty_valid = ($urandom_range(0, 99) < 5);
         bus_if.duty_in    = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 2999) == 0) bus_if.count_in = 9'($urandom_range(0, 511));
      end
      reset = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
